// File: rtl/core_sram_arb_pkg.sv
// Shared types and constants for the core SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_sram_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAN = 1'b1
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;

    // Saturating increment for 32-bit event counters
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/core_sram_rr_arb2.sv
// Two-way round-robin arbiter; prio_q names the port that wins the next conflict.
// Latency: grant is combinational from requests; pointer moves at the clock edge.
// Backpressure: a losing requester simply sees no grant and must hold its request.
module core_sram_rr_arb2
    import core_sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic prio_q;
    logic prio_d;

    // Grant decision; the pointer only moves when both ports contend
    always_comb begin
        gnt_a_o = en_i & req_a_i & (~req_b_i | (prio_q == PORT_A));
        gnt_b_o = en_i & req_b_i & (~req_a_i | (prio_q == PORT_B));
        prio_d  = prio_q;
        if (en_i & req_a_i & req_b_i) begin
            prio_d = gnt_a_o ? PORT_B : PORT_A;
        end
    end

    // Priority pointer register; A wins the first conflict after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio_q <= PORT_A;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/core_sram_arbiter.sv
// Shares one 1rw SRAM macro between ports A/B (round-robin) and zero-fills it on clean_start.
// Latency: grants/macro strobes combinational in the request cycle; read data valid one cycle later.
// Backpressure: losers and all requests during CLEAN see gnt=0 and hold. Optional perf counters: CORE_SRAM_ARB_PERF_EN.
module core_sram_arbiter
    import core_sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  a_req,
    input  logic                  a_wen,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvld,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_wen,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvld,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  clean_start,
    output logic                  clean_busy,
    output logic                  clean_done,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
`ifdef CORE_SRAM_ARB_PERF_EN
   ,input  logic                  perf_clr,
    output logic [31:0]           perf_a_cnt,
    output logic [31:0]           perf_b_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clean_addr_q, clean_addr_d;
    logic                    clean_done_q, clean_done_d;
    logic                    a_rvld_q, b_rvld_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic                    arb_en;

    // Grants are suppressed while cleaning and while reset is asserted
    assign arb_en = (state_q == ARB) & rstn;

    core_sram_rr_arb2 u_rr (
        .clk     (clk),
        .rstn    (rstn),
        .en_i    (arb_en),
        .req_a_i (a_req),
        .req_b_i (b_req),
        .gnt_a_o (a_gnt),
        .gnt_b_o (b_gnt)
    );

    // State, clean address, read-valid pipeline and held macro bus
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ARB;
            clean_addr_q <= '0;
            clean_done_q <= 1'b0;
            a_rvld_q     <= 1'b0;
            b_rvld_q     <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            clean_addr_q <= clean_addr_d;
            clean_done_q <= clean_done_d;
            a_rvld_q     <= a_gnt & ~a_wen;
            b_rvld_q     <= b_gnt & ~b_wen;
            addr_q       <= sram_addr;
            din_q        <= sram_din;
        end
    end

    // Next state: enter CLEAN on clean_start, leave after writing the last word
    always_comb begin
        state_d      = state_q;
        clean_addr_d = clean_addr_q;
        clean_done_d = 1'b0;
        case (state_q)
            ARB: begin
                if (clean_start) begin
                    state_d = CLEAN;
                end
            end
            CLEAN: begin
                if (clean_addr_q == LAST_ADDR) begin
                    state_d      = ARB;
                    clean_addr_d = '0;
                    clean_done_d = 1'b1;
                end else begin
                    clean_addr_d = clean_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Macro bus: clean write, granted port, or idle with address/data held
    always_comb begin
        clean_busy = 1'b0;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_addr  = addr_q;
        sram_din   = din_q;
        if (state_q == CLEAN) begin
            clean_busy = 1'b1;
            sram_csb   = 1'b0;
            sram_web   = 1'b0;
            sram_addr  = clean_addr_q;
            sram_din   = '0;
        end else if (a_gnt) begin
            sram_csb   = 1'b0;
            sram_web   = ~a_wen;
            sram_addr  = a_addr;
            sram_din   = a_wdata;
        end else if (b_gnt) begin
            sram_csb   = 1'b0;
            sram_web   = ~b_wen;
            sram_addr  = b_addr;
            sram_din   = b_wdata;
        end
    end

    assign clean_done = clean_done_q;
    assign a_rvld     = a_rvld_q;
    assign b_rvld     = b_rvld_q;
    assign a_rdata    = a_rvld_q ? sram_dout : '0;
    assign b_rdata    = b_rvld_q ? sram_dout : '0;

`ifdef CORE_SRAM_ARB_PERF_EN
    logic [31:0] perf_a_q, perf_b_q, perf_stall_q;
    logic        stall;

    assign stall = (a_req & ~a_gnt) | (b_req & ~b_gnt);

    // Saturating grant/stall counters with synchronous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_a_q     <= '0;
            perf_b_q     <= '0;
            perf_stall_q <= '0;
        end else if (perf_clr) begin
            perf_a_q     <= '0;
            perf_b_q     <= '0;
            perf_stall_q <= '0;
        end else begin
            if (a_gnt) perf_a_q     <= sat_inc(perf_a_q);
            if (b_gnt) perf_b_q     <= sat_inc(perf_b_q);
            if (stall) perf_stall_q <= sat_inc(perf_stall_q);
        end
    end

    assign perf_a_cnt     = perf_a_q;
    assign perf_b_cnt     = perf_b_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/core_sram_arbiter.md
Name: core_sram_arbiter

Overview:
- Shares one single-port core SRAM macro (1rw, inputs captured on posedge, array read/write on negedge) between two requesters.
- Port A is the host/core_mem interface; port B is the datapath (weight/KV load and MAC-side read).
- Round-robin arbitration with a one-cycle read-return path.
- Built-in clean sequencer zero-fills the whole macro, for KV-cache clean.

Parameters:
- DATA_WIDTH, 32, macro word width.
- ADDR_WIDTH, 10, macro address width; DEPTH = 1<<ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- a_req  in  1  port A request valid.
- a_wen  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_WIDTH  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_gnt  out  1  port A granted this cycle (combinational).
- a_rvld  out  1  port A read data valid.
- a_rdata  out  DATA_WIDTH  port A read data.
- b_req, b_wen, b_addr, b_wdata, b_gnt, b_rvld, b_rdata: same as port A, for port B.
- clean_start  in  1  pulse: zero-fill the whole macro.
- clean_busy  out  1  clean sequence in progress.
- clean_done  out  1  one-cycle pulse after the last clean write.
- sram_csb  out  1  macro chip select, active low.
- sram_web  out  1  macro write enable, active low.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_din  out  DATA_WIDTH  macro write data.
- sram_dout  in  DATA_WIDTH  macro read data (updates at negedge).

Behaviour:
- Reset values: all outputs 0, except sram_csb=1 and sram_web=1.
- Reset also sets state=ARB, rr_ptr=A, clean address=0.
- Reset mid-clean aborts the clean; no clean_done is issued.
- State ARB:
  - Only one requester active: it is granted.
  - Both active: the port other than rr_ptr's last winner is granted; after reset A wins first.
  - rr_ptr updates only on a dual-request grant.
- Grant drives the sram_* outputs combinationally in the same cycle: csb=0, web=~wen, addr, din.
- No request: csb=1, web=1, addr and din hold their previous value.
- A requester holds req/wen/addr/wdata stable until its gnt is seen; a request granted in cycle N completes in cycle N.
- Read return:
  - A granted read in cycle N sets x_rvld=1 in cycle N+1 (registered, one-cycle pulse).
  - x_rdata = sram_dout while x_rvld=1, else 0.
  - Back-to-back reads give one rvld per cycle.
  - Writes never raise rvld.
- clean_start in ARB:
  - Enters CLEAN at the next edge.
  - If a request coincides with clean_start, that request is still granted in that cycle, then the clean begins.
- State CLEAN:
  - a_gnt=b_gnt=0; clean_busy=1.
  - Each cycle: csb=0, web=0, din=0, addr=clean address; clean address increments.
  - The write to DEPTH-1 is the last; the next cycle raises clean_done=1, returns to ARB, and resets the clean address to 0.
  - Clean takes exactly DEPTH cycles of writes.
  - clean_start while in CLEAN is ignored.
  - An rvld owed from the cycle before CLEAN entry is still delivered.
- Requests stay pending (gnt=0) during CLEAN and are serviced in the first ARB cycle.

Optional Feature:
- Macro: CORE_SRAM_ARB_PERF_EN.
- Defined: adds outputs perf_a_cnt, perf_b_cnt, perf_stall_cnt (32 bits each, saturating) and input perf_clr.
  - perf_a_cnt / perf_b_cnt count grants per port.
  - perf_stall_cnt counts cycles with a request pending but not granted (ARB conflict or CLEAN).
  - perf_clr zeroes all three synchronously; reset zeroes them.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (core_sram_arb_pkg):
  - state enum {ARB, CLEAN};
  - port index constants PORT_A=0, PORT_B=1;
  - default DATA_WIDTH/ADDR_WIDTH constants.
- One sub-module: core_sram_rr_arb2 (2-way round-robin grant with pointer register).
- The clean sequencer and read-return stay in the top.

Test Plan:
- Single A write, addr 5, data 0xDEADBEEF; then A read, addr 5 -> a_gnt same cycle; a_rvld one cycle later with a_rdata=0xDEADBEEF; b_rvld stays 0.
- A and B both read for 4 cycles after reset (A addr 1, B addr 2, preloaded 0x11/0x22) -> grants alternate A,B,A,B; rvld/rdata alternate 0x11,0x22 one cycle behind.
- B writes addr 0..7 back-to-back with data=addr -> b_gnt=1 every cycle; subsequent A reads return 0..7.
- Fill addrs with 0xFFFFFFFF, pulse clean_start with an A request pending -> A is granted, then clean_busy for DEPTH cycles with a_gnt=0; clean_done pulse; A reads anywhere return 0.
- Assert rstn=0 mid-clean at addr 100 -> all outputs at reset values immediately; after release, ARB state, A wins the first conflict, no clean_done.
- With CORE_SRAM_ARB_PERF_EN: 10 conflict cycles -> perf_a_cnt=5, perf_b_cnt=5, perf_stall_cnt=10; perf_clr -> all 0.
